// File: rtl/lut_interpolator_if.sv
// Sample/result handshake plus the LUT lookup pair for lut_interpolator.
// slave is the interpolator side; master is the producer/consumer/LUT side.
interface lut_interpolator_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_x;
  logic [ADDR_W-1:0]        lut_address;
  logic signed [DATA_W-1:0] lut_base;
  logic signed [DATA_W-1:0] lut_next;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_y;

  modport slave (
    input  in_valid, in_x, lut_base, lut_next, out_ready,
    output in_ready, lut_address, out_valid, out_y
  );

  modport master (
    output in_valid, in_x, lut_base, lut_next, out_ready,
    input  in_ready, lut_address, out_valid, out_y
  );
endinterface

// File: rtl/lut_interpolator.sv
// Two-stage linear interpolation between adjacent activation-LUT entries.
// Stage 1 captures the LUT pair and fraction, stage 2 produces floor(base + diff*f/2^FRAC_W).
module lut_interpolator #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  lut_interpolator_if.slave  bus
);
  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int PROD_W = DATA_W + FRAC_W + 1;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] nxt;
    logic [FRAC_W-1:0] frac;
  } s1_t;

  logic [STAGES:0]   vld_pipe;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  s1_t               s1_q, s1_d;
  logic [DATA_W-1:0] y_q, y_d;

  logic                     en;
  logic                     accept;
  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] diff_x, frac_x, prod, shifted, sum;
  logic                     unused_hi;

  // Stall only when a result is parked and the consumer refuses it.
  assign en              = !vld_pipe_q[STAGES] || bus.out_ready;
  assign accept          = bus.in_valid && en;
  assign vld_pipe        = {vld_pipe_q, accept};

  assign bus.in_ready    = en;
  assign bus.lut_address = bus.in_x[DATA_W-1:FRAC_W];
  assign bus.out_valid   = vld_pipe_q[STAGES];
  assign bus.out_y       = y_q;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    y_d        = y_q;

    diff    = $signed({s1_q.nxt[DATA_W-1], s1_q.nxt}) - $signed({s1_q.base[DATA_W-1], s1_q.base});
    diff_x  = PROD_W'(diff);
    frac_x  = $signed(PROD_W'(s1_q.frac));
    prod    = diff_x * frac_x;
    // Arithmetic shift floors toward -inf; the result always sits between base and next.
    shifted = prod >>> FRAC_W;
    sum     = $signed(PROD_W'($signed(s1_q.base))) + shifted;

    if (en) begin
      vld_pipe_d = vld_pipe[STAGES-1:0];
      y_d        = sum[DATA_W-1:0];
      if (accept) begin
        s1_d.base = bus.lut_base;
        s1_d.nxt  = bus.lut_next;
        s1_d.frac = bus.in_x[FRAC_W-1:0];
      end
    end
  end

  assign unused_hi = ^sum[PROD_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      y_q        <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      y_q        <= y_d;
    end
  end
endmodule
